// File: rtl/washer_pkg.sv
// Shared washer definitions: run-state encoding
// and counter widths used by run_ctrl and the timer block.
package washer_pkg;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'b00,
    RS_RUN   = 2'b01,
    RS_PAUSE = 2'b10,
    RS_DONE  = 2'b11
  } run_state_e;

  localparam int SEC_W  = 27;
  localparam int BEEP_W = 4;

endpackage

// File: rtl/sec_tick.sv
// Enabled divider: one-cycle tick every N enabled
// cycles; the count restarts whenever en drops.
module sec_tick
  import washer_pkg::*;
#(
  parameter int N = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [SEC_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == SEC_W'(N - 1));
  assign tick   = en & w_last;

  // count while enabled, wrap at N-1, clear when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Washer run-state controller: start/pause key,
// run LED with pause blink, timed end-of-cycle beep.
module run_ctrl
  import washer_pkg::*;
#(
  parameter int N      = 100_000_000,
  parameter int BEEP_S = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_light,
  input  logic       start_pause,
  input  logic [6:0] rest_time,
  output logic [1:0] run_state,
  output logic       run_led,
  output logic       done_beep
);

  localparam logic [SEC_W-1:0] BLINK_LAST =
    SEC_W'(N / 2 - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST =
    BEEP_W'(BEEP_S - 1);

  run_state_e        r_state;
  logic              r_hist;
  logic              r_led;
  logic              r_beep;
  logic [BEEP_W-1:0] r_beep_sec;
  logic [SEC_W-1:0]  r_blink;
  logic              w_press;
  logic              w_zero;
  logic              w_sec_en;
  logic              w_sec_tick;

  assign w_press  = start_pause & ~r_hist;
  assign w_zero   = (rest_time == 7'd0);
  assign w_sec_en = power_light & (r_state == RS_DONE);

  sec_tick #(
    .N (N)
  ) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_sec_en),
    .tick  (w_sec_tick)
  );

  assign run_state = r_state;
  assign run_led   = r_led;
  assign done_beep = r_beep;

  // run-state FSM with registered LED/beep outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RS_IDLE;
      r_hist     <= 1'b1;
      r_led      <= 1'b0;
      r_beep     <= 1'b0;
      r_beep_sec <= '0;
      r_blink    <= '0;
    end else begin
      r_hist <= start_pause;
      if (!power_light) begin
        r_state    <= RS_IDLE;
        r_led      <= 1'b0;
        r_beep     <= 1'b0;
        r_beep_sec <= '0;
        r_blink    <= '0;
      end else begin
        unique case (r_state)
          RS_IDLE: begin
            if (w_press && !w_zero) begin
              r_state <= RS_RUN;
              r_led   <= 1'b1;
            end
          end
          RS_RUN: begin
            if (w_zero) begin
              r_state    <= RS_DONE;
              r_led      <= 1'b1;
              r_beep     <= 1'b1;
              r_beep_sec <= '0;
            end else if (w_press) begin
              r_state <= RS_PAUSE;
              r_led   <= 1'b1;
              r_blink <= '0;
            end
          end
          RS_PAUSE: begin
            if (w_press) begin
              r_blink <= '0;
              r_led   <= 1'b1;
              if (w_zero) begin
                r_state    <= RS_DONE;
                r_beep     <= 1'b1;
                r_beep_sec <= '0;
              end else begin
                r_state <= RS_RUN;
              end
            end else if (r_blink == BLINK_LAST) begin
              r_blink <= '0;
              r_led   <= ~r_led;
            end else begin
              r_blink <= r_blink + 1'b1;
            end
          end
          RS_DONE: begin
            if (w_press ||
                (w_sec_tick &&
                 r_beep_sec == BEEP_LAST)) begin
              r_state    <= RS_IDLE;
              r_led      <= 1'b0;
              r_beep     <= 1'b0;
              r_beep_sec <= '0;
            end else if (w_sec_tick) begin
              r_beep_sec <= r_beep_sec + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Run-state controller for the washer timer path. It consumes the 7-bit `rest_time` countdown from the order/timer block and the debounced start/pause key. It produces the 2-bit `run_state` that the timer block uses to decide between presetting and counting down. It also drives the run LED and the end-of-cycle beeper.

Parameters:
N, 100_000_000, clock cycles per second (1 Hz tick period).
BEEP_S, 5, seconds `done_beep` stays high after completion, range 1..15.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous, active-low.
power_light  input  1  power on (1) / off (0).
start_pause  input  1  debounced start/pause key, level, active-high.
rest_time  input  7  remaining time from the timer block, 0..69.
run_state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
run_led  output  1  run indicator.
done_beep  output  1  beeper enable.

Behaviour:
- Reset (`rst_n`=0, async):
  - `run_state`=IDLE, `run_led`=0, `done_beep`=0.
  - All counters cleared.
  - Key history register = 1, so a key held through reset is not a press.
- Press: `start_pause`=1 sampled while key history=0.
  - History updates every cycle.
  - At most one press per key-down, regardless of hold length.
- All transitions and output updates are registered. A transition takes effect at the clock edge that samples the condition.
- `power_light`=0 (synchronous, highest priority after reset):
  - State goes to IDLE; all outputs and counters cleared.
  - Key history keeps tracking, so no press is ever detected while power is off.
- FSM:
  - IDLE: press and `rest_time`!=0 -> RUN. Press with `rest_time`=0 is ignored and stays IDLE.
  - RUN:
    - `rest_time`=0 -> DONE. This covers both natural countdown and the timer block's clear-time.
    - Otherwise press -> PAUSE.
    - Press and `rest_time`=0 in the same cycle -> DONE (zero wins).
  - PAUSE:
    - Press -> RUN if `rest_time`!=0, else -> DONE.
    - Timer block holds `rest_time` while state!=RUN.
  - DONE:
    - `done_beep`=1 on entry for BEEP_S seconds, then -> IDLE with `done_beep`=0.
    - A press in DONE -> IDLE immediately, `done_beep`=0.
- Second timer (`sec_cnt`, width 27):
  - Counts 0..N-1 in DONE only; cleared in every other state.
  - On wrap, `beep_sec` (4 bits) increments.
  - Exit when `beep_sec`=BEEP_S-1 and `sec_cnt`=N-1, i.e. exactly BEEP_S*N cycles in DONE.
- `run_led` by state:
  - IDLE: 0.
  - RUN: 1.
  - PAUSE: blinks at 1 Hz. Starts at 1 on entry, toggles every N/2 cycles via `blink_cnt`, which is cleared on PAUSE entry and exit.
  - DONE: 1.
- Boundary cases:
  - `rest_time` changing during IDLE (user presetting) has no effect.
  - Reset mid-DONE cancels the beep immediately.
  - Power-off mid-RUN -> IDLE next edge; restarting requires a new press.

Decomposition:
- Package `washer_pkg`:
  - Run-state constants RS_IDLE=2'b00, RS_RUN=2'b01, RS_PAUSE=2'b10, RS_DONE=2'b11.
  - These are shared with the timer block, which keys preset on RS_IDLE and countdown on RS_RUN.
- One natural sub-module, `sec_tick`:
  - Parameter N, inputs `clk`/`rst_n`/`en`, output `tick`, a 1-cycle pulse every N enabled cycles.
  - Counter clears when `en`=0.
  - Reused by the timer block later.
- The blink divider stays inline.

Test Plan (N=10, BEEP_S=3):
- Reset release with `start_pause` held high and `rest_time`=20 -> stays IDLE until key released and pressed again, then RUN one cycle after the press, `run_led`=1.
- IDLE, `rest_time`=0, press -> `run_state` remains 00, `run_led`=0.
- RUN with `rest_time`=10, press -> PAUSE; `run_led`=1 for 5 cycles, 0 for 5, repeating; second press -> RUN, `run_led`=1.
- RUN, `rest_time` drops 1->0 -> DONE next edge; `done_beep`=1 for exactly 30 cycles; then IDLE with `done_beep`=0.
- DONE, press at cycle 7 -> IDLE next edge, `done_beep`=0; press in same cycle as `rest_time`=0 in RUN -> DONE, not PAUSE.
- RUN, `power_light`=0 for one cycle -> IDLE, all outputs 0; power back on with key still held -> no transition.
